data_sram_resp: RTL and testbench
=================================

Name: data_sram_resp

Overview:
- Responder end of the SRAM-like data bus that the EX stage drives (req/wr/size/wstrb/addr/wdata out; addr_ok/data_ok/rdata back).
- Word-organised backing memory plus an in-order outstanding-request queue with programmable response latency and external address-phase backpressure.
- Used as the data-side memory model in core-level simulation and as the slave skeleton for the later AXI bridge.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2^ADDR_W 32-bit words.
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests; power of two, ≥ 1.
- LATENCY, 2, cycles from address handshake to data_ok; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, carried with the entry.
- data_sram_wstrb  in  4  byte-lane write enables.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data, already lane-replicated by the master.
- stall  in  1  forces addr_ok low while high.
- data_sram_addr_ok  out  1  address-phase accept.
- data_sram_data_ok  out  1  one-cycle response pulse, one per accepted request.
- data_sram_rdata  out  32  read data, valid with data_ok.

Behaviour:
- Address phase
  - addr_ok = ~reset & ~stall & (count < DEPTH). It is combinational and does not depend on req.
  - A request is accepted in any cycle with req & addr_ok.
  - Full means no accept, even if a pop happens in the same cycle. There is no full-bypass.
- Memory index
  - Index = addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias.
  - addr[1:0] is ignored by the memory. Byte and half extraction stay in the MEM stage.
- Write on accept
  - For each i with wstrb[i]=1: mem[idx][8i+7:8i] <= wdata[8i+7:8i] at the accept edge.
  - wr=1 with wstrb=0 writes nothing and still produces data_ok.
- Read on accept
  - The full word mem[idx] is captured into the entry at the accept edge.
  - A read accepted the cycle after a write to the same index returns the new data.
- Queue
  - Circular buffer with wrap-around head/tail pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
  - Entry fields: wr, size, rdata, timer.
  - On push, timer is loaded with LATENCY-1.
  - Every cycle, each valid entry with timer > 0 decrements. The timer saturates at 0.
- Response
  - data_ok = head valid & head.timer == 0.
  - Responses are strictly in order. An entry whose timer has expired waits behind an older unanswered entry.
  - The head pops on the same edge data_ok is seen.
  - A request accepted in cycle T gives data_ok no earlier than cycle T+LATENCY. Back-to-back accepts give back-to-back data_ok.
- rdata
  - Equals the head entry's rdata when data_ok=1 and the head is a read.
  - 0 otherwise, including write responses.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Reset
  - In cycles where reset=1: addr_ok=0, data_ok=0, rdata=0.
  - At the reset edge: count=0, head=tail=0, all entries invalid.
  - Outstanding requests are dropped and never answered.
  - Memory contents are preserved across reset and are not initialised by reset.
  - Simulation init: all words 0.
- stall
  - Only blocks acceptance.
  - Queued entries keep aging and responding while stall=1.

Decomposition:
- Shared package holds:
  - the size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the entry field widths;
  - a function mapping wstrb to a bit mask.
- One sub-module, data_sram_resp_fifo, holds the DEPTH-entry circular queue with per-entry timers.
  - Ports: push/pop, full, count, head fields, head_ready.
- The top level holds the memory array, the address handshake and the output muxing.

Test Plan:
- Full-word write then read:
  - Reset; write addr 0x100, wdata 0xDEADBEEF, wstrb 0xF in cycle T.
  - Expect data_ok at T+2 with rdata 0.
  - Read 0x100 at T+3; expect data_ok at T+5 with rdata 0xDEADBEEF.
- Partial writes:
  - Word 0x40 holds 0x11223344.
  - Write wstrb 0x2, wdata 0xAAAAAAAA; then write wstrb 0xC, wdata 0x5555BBBB.
  - Read 0x40; expect 0x5555AA44.
- Full queue (DEPTH=4):
  - Issue 6 back-to-back reads with stall=0.
  - Expect addr_ok=0 in the cycle the 5th is offered.
  - Expect 6 data_ok pulses in issue order, each with the correct word.
- Backpressure:
  - stall=1 for 3 cycles while req=1; expect no accept.
  - A request already queued still returns data_ok during the stall.
  - The accept happens in the first cycle stall=0.
- Reset mid-operation:
  - Queue 3 reads, then assert reset for 1 cycle.
  - Expect no data_ok for those reads and count=0 afterwards.
  - A write done before reset is still readable after reset.
- Aliasing with LATENCY=1:
  - Write 0x12345678 to addr 0x1000 (word index 0 when ADDR_W=10).
  - Read addr 0x0; expect rdata 0x12345678 with data_ok exactly 1 cycle after accept.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_resp_pkg
// Shared definitions for the data-side SRAM-bus responder: access-size
// encodings, entry field widths and the byte-strobe to bit-mask helper.
// -----------------------------------------------------------------------------
package data_sram_resp_pkg;

  // Access size as driven on data_sram_size. Carried with each entry only.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int SIZE_W = 2;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  // Expand byte-lane enables into a per-bit mask (lane i -> bits 8i+7:8i).
  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// -----------------------------------------------------------------------------
// data_sram_resp_fifo
// In-order queue of accepted-but-unanswered requests. Each entry carries
// wr/size/rdata plus a countdown timer loaded with LATENCY-1 on push; the
// head may be popped once its timer has reached zero.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_push             enqueue an entry (ignored when full)
//   i_push_wr/size/rdata  fields of the pushed entry
//   i_pop              dequeue the head (ignored when empty)
//   o_full             count == DEPTH
//   o_count            number of valid entries
//   o_head_wr/size/rdata  head entry fields
//   o_head_ready       head valid and its timer expired
// -----------------------------------------------------------------------------
module data_sram_resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_push_wr,
  input  logic [SIZE_W-1:0] i_push_size,
  input  logic [DATA_W-1:0] i_push_rdata,
  input  logic              i_pop,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_head_wr,
  output logic [SIZE_W-1:0] o_head_size,
  output logic [DATA_W-1:0] o_head_rdata,
  output logic              o_head_ready
);

  localparam int TIMER_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LATENCY - 1);

  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_valid;
  logic               r_wr    [DEPTH];
  logic [SIZE_W-1:0]  r_size  [DEPTH];
  logic [DATA_W-1:0]  r_rdata [DEPTH];
  logic [TIMER_W-1:0] r_timer [DEPTH];

  logic w_push;
  logic w_pop;

  // Wrap explicitly so non-power-of-two DEPTH values would still be safe.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & r_valid[r_head];

  // Control state: pointers, occupancy and per-entry valid bits.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_next(r_head);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= ptr_next(r_tail);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload and timers.
  // NOTE: payload storage has no reset; r_valid alone decides whether an
  // entry means anything, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_timer[i] != '0)) begin
        r_timer[i] <= r_timer[i] - 1'b1;
      end
    end
    if (w_push) begin
      r_wr[r_tail]    <= i_push_wr;
      r_size[r_tail]  <= i_push_size;
      r_rdata[r_tail] <= i_push_rdata;
      r_timer[r_tail] <= TIMER_LOAD;
    end
  end

  assign o_head_wr    = r_wr[r_head];
  assign o_head_size  = r_size[r_head];
  assign o_head_rdata = r_rdata[r_head];
  assign o_head_ready = r_valid[r_head] && (r_timer[r_head] == '0);

endmodule

// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
// Responder for the SRAM-like data bus: word-organised backing memory, an
// address handshake with external stall, and in-order responses after a
// fixed LATENCY through data_sram_resp_fifo.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   data_sram_req        request valid
//   data_sram_wr         1 = write, 0 = read
//   data_sram_size       access size (carried only)
//   data_sram_wstrb      byte-lane write enables
//   data_sram_addr       byte address; word index = addr[ADDR_W+1:2]
//   data_sram_wdata      lane-replicated write data
//   stall                holds addr_ok low
//   data_sram_addr_ok    address-phase accept (independent of req)
//   data_sram_data_ok    one-cycle response pulse
//   data_sram_rdata      read data with data_ok, else 0
// -----------------------------------------------------------------------------
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  input  logic              stall,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Contents survive reset; simulation starts from all-zero words.
  logic [DATA_W-1:0] r_mem [2**ADDR_W] = '{default: '0};

  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_accept;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic              w_head_wr;
  logic [SIZE_W-1:0] w_head_size;
  logic [DATA_W-1:0] w_head_rdata;
  logic              w_head_ready;
  logic              w_unused;

  // Byte offset and upper bits are ignored: sub-word extraction belongs to
  // the MEM stage and out-of-range addresses alias onto the array.
  assign w_idx     = data_sram_addr[ADDR_W+1:2];
  assign w_mask    = strb_to_mask(data_sram_wstrb);
  assign w_rd_word = r_mem[w_idx];

  // No full-bypass: a pop in the same cycle does not open a slot early.
  assign data_sram_addr_ok = ~reset & ~stall & ~w_full;
  assign w_accept          = data_sram_req & data_sram_addr_ok;

  always_ff @(posedge clk) begin
    if (w_accept && data_sram_wr) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (data_sram_wdata & w_mask);
    end
  end

  data_sram_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_accept),
    .i_push_wr    (data_sram_wr),
    .i_push_size  (data_sram_size),
    .i_push_rdata (w_rd_word),
    .i_pop        (data_sram_data_ok),
    .o_full       (w_full),
    .o_count      (w_count),
    .o_head_wr    (w_head_wr),
    .o_head_size  (w_head_size),
    .o_head_rdata (w_head_rdata),
    .o_head_ready (w_head_ready)
  );

  assign data_sram_data_ok = ~reset & w_head_ready;

  // NOTE: the output is assigned a default before the conditional so no
  // latch is inferred when the condition is false.
  always_comb begin
    data_sram_rdata = '0;
    if (data_sram_data_ok && !w_head_wr) begin
      data_sram_rdata = w_head_rdata;
    end
  end

  assign w_unused = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0], w_head_size};

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;
  import data_sram_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;

  logic        d_ok, d_dok;
  logic [31:0] d_rd;
  logic        s_ok, s_dok;
  logic [31:0] s_rd;
  logic        f_ok, f_dok;
  logic [31:0] f_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Default configuration (LATENCY=2).
  data_sram_resp u_dut (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .stall(stall), .data_sram_addr_ok(d_ok),
    .data_sram_data_ok(d_dok), .data_sram_rdata(d_rd)
  );

  // Long latency so four accepts can fill the queue.
  data_sram_resp #(.LATENCY(6)) u_slow (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .stall(stall), .data_sram_addr_ok(s_ok),
    .data_sram_data_ok(s_dok), .data_sram_rdata(s_rd)
  );

  // Minimum latency.
  data_sram_resp #(.LATENCY(1)) u_fast (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .stall(stall), .data_sram_addr_ok(f_ok),
    .data_sram_data_ok(f_dok), .data_sram_rdata(f_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle; inputs change 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rq, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req   = rq;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    size  = SZ_WORD;
  endtask

  // Single write then enough idle cycles for every instance to drain.
  task automatic write_idle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b1, 1'b1, a, d, s);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (8) cyc();
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    cyc();
    cyc();
    #1;
    check("rst_addr_ok", d_ok, 1'b0);
    check("rst_data_ok", d_dok, 1'b0);
    check("rst_rdata", d_rd, 32'h0);
    check("rst_count", u_slow.w_count, '0);
    cyc();
    reset = 1'b0;

    // Full-word write then read.
    drive(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1 check("wr_accept", d_ok, 1'b1);
    check("wr_no_early_ok", d_dok, 1'b0);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1 check("wr_t1_no_ok", d_dok, 1'b0);
    cyc();
    #1 check("wr_t2_data_ok", d_dok, 1'b1);
    check("wr_t2_rdata_zero", d_rd, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h100, '0, '0);
    #1 check("rd_accept", d_ok, 1'b1);
    check("rd_t3_no_ok", d_dok, 1'b0);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1 check("rd_t4_no_ok", d_dok, 1'b0);
    cyc();
    #1 check("rd_t5_data_ok", d_dok, 1'b1);
    check("rd_t5_rdata", d_rd, 32'hDEADBEEF);
    cyc();
    repeat (8) cyc();

    // Partial writes, then a read the cycle right after the last write.
    write_idle(32'h40, 32'h11223344, 4'hF);
    drive(1'b1, 1'b1, 32'h40, 32'hAAAAAAAA, 4'h2);
    cyc();
    drive(1'b1, 1'b1, 32'h40, 32'h5555BBBB, 4'hC);
    cyc();
    drive(1'b1, 1'b0, 32'h40, '0, '0);
    #1 check("part_rd_accept", d_ok, 1'b1);
    check("part_w1_resp", d_dok, 1'b1);
    check("part_w1_rdata", d_rd, 32'h0);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1 check("part_w2_resp", d_dok, 1'b1);
    cyc();
    #1 check("part_rd_resp", d_dok, 1'b1);
    check("part_rd_rdata", d_rd, 32'h5555AA44);
    cyc();
    repeat (8) cyc();

    // Full queue on the LATENCY=6 instance: six reads of known words.
    for (int i = 0; i < 6; i++) write_idle(32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
    for (int c = 0; c < 16; c++) begin
      int  o;
      int  rd_i;
      o    = (c < 4) ? c : (c <= 7) ? 4 : (c == 8) ? 5 : -1;
      rd_i = (c >= 6 && c <= 9) ? c - 6 : (c == 13) ? 4 : (c == 14) ? 5 : -1;
      if (o >= 0) drive(1'b1, 1'b0, 32'h200 + 32'(4 * o), '0, '0);
      else        drive(1'b0, 1'b0, '0, '0, '0);
      #1;
      if (o >= 0) check($sformatf("full_addr_ok_c%0d", c), s_ok, (c < 4 || c >= 7) ? 1'b1 : 1'b0);
      check($sformatf("full_data_ok_c%0d", c), s_dok, (rd_i >= 0) ? 1'b1 : 1'b0);
      if (rd_i >= 0) check($sformatf("full_rdata_c%0d", c), s_rd, 32'hC0DE0000 + 32'(rd_i));
      cyc();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (8) cyc();

    // Backpressure on the default instance.
    drive(1'b1, 1'b0, 32'h200, '0, '0);
    #1 check("bp_first_accept", d_ok, 1'b1);
    cyc();
    stall = 1'b1;
    drive(1'b1, 1'b0, 32'h204, '0, '0);
    #1 check("bp_s1_addr_ok", d_ok, 1'b0);
    check("bp_s1_data_ok", d_dok, 1'b0);
    cyc();
    #1 check("bp_s2_addr_ok", d_ok, 1'b0);
    check("bp_s2_data_ok", d_dok, 1'b1);
    check("bp_s2_rdata", d_rd, 32'hC0DE0000);
    cyc();
    #1 check("bp_s3_addr_ok", d_ok, 1'b0);
    cyc();
    stall = 1'b0;
    #1 check("bp_release_accept", d_ok, 1'b1);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1 check("bp_no_early_ok", d_dok, 1'b0);
    cyc();
    #1 check("bp_resp", d_dok, 1'b1);
    check("bp_resp_rdata", d_rd, 32'hC0DE0001);
    cyc();
    repeat (8) cyc();

    // Reset with three reads outstanding on the LATENCY=6 instance.
    write_idle(32'h300, 32'h0BADF00D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h300, '0, '0);
      cyc();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    #1 check("mid_rst_addr_ok", s_ok, 1'b0);
    check("mid_rst_data_ok", s_dok, 1'b0);
    check("mid_rst_rdata", s_rd, 32'h0);
    cyc();
    reset = 1'b0;
    #1 check("mid_rst_count", u_slow.w_count, '0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mid_rst_dropped_%0d", i), s_dok, 1'b0);
      cyc();
      #1;
    end
    cyc();
    drive(1'b1, 1'b0, 32'h300, '0, '0);
    #1 check("post_rst_accept", s_ok, 1'b1);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (5) cyc();
    #1 check("post_rst_data_ok", s_dok, 1'b1);
    check("post_rst_rdata", s_rd, 32'h0BADF00D);
    cyc();
    repeat (8) cyc();

    // Write with no lanes enabled: responds, changes nothing.
    drive(1'b1, 1'b1, 32'h300, 32'hFFFFFFFF, 4'h0);
    #1 check("zstrb_accept", d_ok, 1'b1);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    cyc();
    #1 check("zstrb_data_ok", d_dok, 1'b1);
    check("zstrb_rdata", d_rd, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h300, '0, '0);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    cyc();
    #1 check("zstrb_readback_ok", d_dok, 1'b1);
    check("zstrb_readback", d_rd, 32'h0BADF00D);
    cyc();
    repeat (8) cyc();

    // Aliasing on the LATENCY=1 instance: 0x1000 and 0x0 share word 0.
    write_idle(32'h1000, 32'h12345678, 4'hF);
    drive(1'b1, 1'b0, 32'h0, '0, '0);
    #1 check("alias_accept", f_ok, 1'b1);
    check("alias_no_ok_same_cycle", f_dok, 1'b0);
    cyc();
    drive(1'b0, 1'b0, '0, '0, '0);
    #1 check("alias_data_ok", f_dok, 1'b1);
    check("alias_rdata", f_rd, 32'h12345678);
    cyc();
    #1 check("alias_single_pulse", f_dok, 1'b0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
